// File: rtl/tetris_board_renderer.sv
// Tetris playfield pixel source: double-buffered 10x20 cell memory, frame and
// background, two-cycle coordinate-to-colour pipeline with vblank-only bank swaps.
module tetris_board_renderer #(
   parameter int          BOARD_X     = 240,
   parameter int          BOARD_Y     = 80,
   parameter int          CELL_SHIFT  = 4,
   parameter int          FRAME_W     = 4,
   parameter int          V_SWAP      = 480,
   parameter logic [11:0] BG_COLOR    = 12'h222,
   parameter logic [11:0] FRAME_COLOR = 12'hAAA,
   parameter logic [11:0] EMPTY_COLOR = 12'h111
) (
   input  logic        clk_25_175,
   input  logic        reset,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   output logic [11:0] pixstream,
   input  logic        wr_en,
   input  logic [3:0]  wr_col,
   input  logic [4:0]  wr_row,
   input  logic [2:0]  wr_color,
   input  logic        clr_req,
   output logic        busy,
   input  logic        swap_req,
   output logic        swap_ack
);

   localparam int                CELLS     = 200;
   localparam int                CELL_PX   = 1 << CELL_SHIFT;
   localparam logic signed [10:0] FIELD_W  = 11'(10 * CELL_PX);
   localparam logic signed [10:0] FIELD_H  = 11'(20 * CELL_PX);
   localparam logic signed [10:0] FW       = 11'(FRAME_W);
   localparam logic [7:0]        LAST_ADDR = 8'(CELLS - 1);

   typedef enum logic       {CLR_IDLE, CLR_RUN} clr_state_t;
   typedef enum logic [1:0] {REG_BG, REG_FRAME, REG_FIELD} region_t;

   clr_state_t  clr_state, clr_state_nx;
   logic [7:0]  clr_cnt, clr_cnt_nx;
   logic        front;
   logic        swap_fire;
   logic        wr_ok;
   logic [7:0]  wr_addr;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [2:0]  mem_wdata;
   logic [2:0]  bank0 [CELLS];
   logic [2:0]  bank1 [CELLS];
   logic [2:0]  rd_data;
   logic [7:0]  rd_addr;
   logic signed [10:0] dx, dy;
   logic        in_field, in_box;
   region_t     region_q;
   logic        outline_q;
   logic [11:0] cell_rgb, pix_nx;

   // ---------------- clear sequencer ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_25_175) begin
      if (!reset) begin
         clr_state <= CLR_IDLE;
         clr_cnt   <= '0;
      end else begin
         clr_state <= clr_state_nx;
         clr_cnt   <= clr_cnt_nx;
      end
   end

   // NOTE: defaults first so no path through this block leaves a target
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      clr_state_nx = clr_state;
      clr_cnt_nx   = clr_cnt;
      case (clr_state)
         CLR_IDLE: if (clr_req) begin
            clr_state_nx = CLR_RUN;
            clr_cnt_nx   = '0;
         end
         CLR_RUN: if (clr_cnt == LAST_ADDR) begin
            clr_state_nx = CLR_IDLE;
            clr_cnt_nx   = '0;
         end else begin
            clr_cnt_nx = clr_cnt + 8'd1;
         end
         default: clr_state_nx = CLR_IDLE;
      endcase
   end

   assign busy = (clr_state == CLR_RUN);

   // ---------------- write port (game writes or clear) ----------------
   always_comb begin
      wr_ok     = wr_en && !busy && (wr_col <= 4'd9) && (wr_row <= 5'd19);
      wr_addr   = 8'(wr_row) * 8'd10 + 8'(wr_col);
      mem_we    = reset && (busy || wr_ok);
      mem_waddr = busy ? clr_cnt : wr_addr;
      mem_wdata = busy ? 3'd0 : wr_color;
   end

   // ---------------- bank swap ----------------
   assign swap_fire = (vpos == 10'(V_SWAP)) && (hpos == '0) && swap_req && !busy;

   always_ff @(posedge clk_25_175) begin
      if (!reset) begin
         front    <= 1'b0;
         swap_ack <= 1'b0;
      end else begin
         swap_ack <= swap_fire;
         if (swap_fire) front <= !front;
      end
   end

   // ---------------- cell memory ----------------
   // NOTE: the banks carry no reset so they map onto plain RAM; the game
   // clears them with clr_req. Writes always target the pre-edge back bank.
   always_ff @(posedge clk_25_175) begin
      if (mem_we && front)  bank0[mem_waddr] <= mem_wdata;
      if (mem_we && !front) bank1[mem_waddr] <= mem_wdata;
      rd_data <= front ? bank1[rd_addr] : bank0[rd_addr];
   end

   // ---------------- stage 1: classify and address ----------------
   always_comb begin
      dx       = $signed({1'b0, hpos}) - $signed(11'(BOARD_X));
      dy       = $signed({1'b0, vpos}) - $signed(11'(BOARD_Y));
      in_field = !dx[10] && (dx < FIELD_W) && !dy[10] && (dy < FIELD_H);
      in_box   = (dx >= -FW) && (dx < FIELD_W + FW) && (dy >= -FW) && (dy < FIELD_H + FW);
      rd_addr  = in_field ? 8'(dy[10:CELL_SHIFT]) * 8'd10 + 8'(dx[10:CELL_SHIFT]) : '0;
   end

   always_ff @(posedge clk_25_175) begin
      if (!reset) begin
         region_q  <= REG_BG;
         outline_q <= 1'b0;
      end else begin
         region_q  <= in_field ? REG_FIELD : (in_box ? REG_FRAME : REG_BG);
         outline_q <= (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);
      end
   end

   // ---------------- stage 2: palette and output ----------------
   function automatic logic [11:0] cell_color(input logic [2:0] idx);
      case (idx)
         3'd1:    return 12'h0FF;
         3'd2:    return 12'h0FF & 12'h0FF;
         3'd3:    return 12'hF0A;
         3'd4:    return 12'h0F0;
         3'd5:    return 12'h00F;
         3'd6:    return 12'hF00;
         3'd7:    return 12'h08F;
         default: return EMPTY_COLOR;
      endcase
   endfunction

   always_comb begin
      cell_rgb = cell_color(rd_data);
      if (rd_data == 3'd1) cell_rgb = 12'hFF0;
      // Outlined cells halve every nibble to draw a darker edge.
      if (outline_q && (rd_data != 3'd0))
         cell_rgb = {1'b0, cell_rgb[11:9], 1'b0, cell_rgb[7:5], 1'b0, cell_rgb[3:1]};
      case (region_q)
         REG_FIELD: pix_nx = cell_rgb;
         REG_FRAME: pix_nx = FRAME_COLOR;
         default:   pix_nx = BG_COLOR;
      endcase
   end

   always_ff @(posedge clk_25_175) begin
      if (!reset) pixstream <= '0;
      else        pixstream <= pix_nx;
   end

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Scoreboard bench for tetris_board_renderer: probes pixels against a cell-level
// reference model and checks clear, write filtering and vblank swap handshakes.
module tb_tetris_board_renderer;

   localparam int BX = 240;
   localparam int BY = 80;

   logic        clk_25_175 = 1'b0;
   logic        reset      = 1'b0;
   logic [9:0]  hpos       = '0;
   logic [9:0]  vpos       = '0;
   logic [11:0] pixstream;
   logic        wr_en      = 1'b0;
   logic [3:0]  wr_col     = '0;
   logic [4:0]  wr_row     = '0;
   logic [2:0]  wr_color   = '0;
   logic        clr_req    = 1'b0;
   logic        busy;
   logic        swap_req   = 1'b0;
   logic        swap_ack;

   tetris_board_renderer dut (
      .clk_25_175 (clk_25_175),
      .reset      (reset),
      .hpos       (hpos),
      .vpos       (vpos),
      .pixstream  (pixstream),
      .wr_en      (wr_en),
      .wr_col     (wr_col),
      .wr_row     (wr_row),
      .wr_color   (wr_color),
      .clr_req    (clr_req),
      .busy       (busy),
      .swap_req   (swap_req),
      .swap_ack   (swap_ack)
   );

   always #20 clk_25_175 = ~clk_25_175;

   typedef struct {
      logic [11:0] exp;
      int          x;
      int          y;
   } px_t;

   px_t        sb_q[$];
   int         tests = 0;
   int         fails = 0;
   int         model_bank [2][200];
   int         model_front = 0;
   bit         model_busy  = 0;
   logic       probe       = 1'b0;
   logic [1:0] vld_pipe    = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int palette(input int idx);
      case (idx)
         1: return 'hFF0;
         2: return 'h0FF;
         3: return 'hF0A;
         4: return 'h0F0;
         5: return 'h00F;
         6: return 'hF00;
         7: return 'h08F;
         default: return 'h111;
      endcase
   endfunction

   // Reference: geometry from plain integer arithmetic over the cell model.
   function automatic logic [11:0] ref_pixel(input int x, input int y);
      int dx = x - BX;
      int dy = y - BY;
      int idx, c, r, g, b;
      if (dx >= 0 && dx < 160 && dy >= 0 && dy < 320) begin
         idx = model_bank[model_front][(dy / 16) * 10 + dx / 16];
         c   = palette(idx);
         if (idx != 0 && (dx % 16 == 0 || dy % 16 == 0)) begin
            b = c / 256; g = (c / 16) % 16; r = c % 16;
            c = (b / 2) * 256 + (g / 2) * 16 + r / 2;
         end
         return 12'(c);
      end
      if (dx >= -4 && dx < 164 && dy >= -4 && dy < 324) return 12'hAAA;
      return 12'h222;
   endfunction

   function automatic void model_write(input int col, input int row, input int color);
      if (col <= 9 && row <= 19 && !model_busy)
         model_bank[1 - model_front][row * 10 + col] = color;
   endfunction

   // Output monitor: every probed pixel emerges two edges after it was driven.
   always @(posedge clk_25_175) vld_pipe <= {vld_pipe[0], probe};

   always @(negedge clk_25_175) begin
      px_t e;
      if (vld_pipe[1]) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: pixel %0h with no expectation", pixstream);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("pix(%0d,%0d)", e.x, e.y), {20'd0, pixstream}, {20'd0, e.exp});
         end
      end
   end

   task automatic probe_px(input int x, input int y);
      px_t e;
      hpos  = 10'(x);
      vpos  = 10'(y);
      probe = 1'b1;
      e.exp = ref_pixel(x, y);
      e.x   = x;
      e.y   = y;
      sb_q.push_back(e);
      @(negedge clk_25_175);
      probe = 1'b0;
   endtask

   task automatic do_write(input int col, input int row, input int color);
      wr_en    = 1'b1;
      wr_col   = 4'(col);
      wr_row   = 5'(row);
      wr_color = 3'(color);
      model_write(col, row, color);
      @(negedge clk_25_175);
      wr_en = 1'b0;
   endtask

   task automatic do_swap(input bit expect_ack, input bit with_wr,
                          input int col, input int row, input int color);
      swap_req = 1'b1;
      vpos     = 10'd480;
      hpos     = 10'd0;
      if (with_wr) begin
         wr_en    = 1'b1;
         wr_col   = 4'(col);
         wr_row   = 5'(row);
         wr_color = 3'(color);
         model_write(col, row, color);
      end
      @(negedge clk_25_175);
      wr_en = 1'b0;
      check("swap_ack_at_vswap", {31'd0, swap_ack}, {31'd0, expect_ack});
      if (expect_ack) model_front = 1 - model_front;
      swap_req = 1'b0;
      hpos     = 10'd1;
      @(negedge clk_25_175);
      check("swap_ack_one_cycle", {31'd0, swap_ack}, 32'd0);
      vpos = 10'd0;
      hpos = 10'd0;
   endtask

   // mode 0: plain clear; 1: blocked swap and ignored write mid-clear; 2: reset at count 50.
   task automatic do_clear(input int mode);
      int n = 0;
      int back = 1 - model_front;
      clr_req = 1'b1;
      if (mode != 2) for (int a = 0; a < 200; a++) model_bank[back][a] = 0;
      model_busy = 1;
      @(negedge clk_25_175);
      clr_req = 1'b0;
      while (busy && n < 1000) begin
         n++;
         if (mode == 1 && n == 100) begin
            swap_req = 1'b1; vpos = 10'd480; hpos = 10'd0;
            wr_en = 1'b1; wr_col = 4'd0; wr_row = 5'd0; wr_color = 3'd7;
            model_write(0, 0, 7);
         end
         if (mode == 2 && n == 50) begin
            reset = 1'b0; swap_req = 1'b1; vpos = 10'd480; hpos = 10'd0;
         end
         @(negedge clk_25_175);
         if (mode == 1 && n == 100) begin
            wr_en = 1'b0; hpos = 10'd1;
            check("no_swap_while_busy", {31'd0, swap_ack}, 32'd0);
         end
         if (mode == 2 && n == 50) begin
            check("busy_after_reset", {31'd0, busy}, 32'd0);
            check("ack_after_reset", {31'd0, swap_ack}, 32'd0);
            reset = 1'b1; swap_req = 1'b0; hpos = 10'd1;
            model_front = 0;
            for (int a = 0; a < 45; a++)  model_bank[back][a] = 0;
            for (int a = 45; a < 56; a++) model_bank[back][a] = -1;
            break;
         end
      end
      if (mode != 2) check("clear_cycles", n, 200);
      model_busy = 0;
   endtask

   task automatic scan_board();
      for (int a = 0; a < 200; a++)
         if (model_bank[model_front][a] >= 0)
            probe_px(BX + (a % 10) * 16 + int'($urandom_range(0, 15)),
                     BY + (a / 10) * 16 + int'($urandom_range(0, 15)));
   endtask

   initial begin
      repeat (3) @(posedge clk_25_175);
      @(negedge clk_25_175);
      check("reset_pixstream", {20'd0, pixstream}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_swap_ack", {31'd0, swap_ack}, 32'd0);
      reset = 1'b1;
      probe_px(0, 0);

      // Bring both banks to a known empty state.
      do_clear(0);
      do_swap(1, 0, 0, 0, 0);
      do_clear(0);

      do_write(3, 5, 5);
      do_swap(1, 0, 0, 0, 0);
      probe_px(BX + 56, BY + 88);
      probe_px(BX + 48, BY + 88);
      probe_px(BX - 2, BY + 10);
      probe_px(BX + 159, BY + 319);

      // Random writes including out-of-range coordinates, then full readback.
      repeat (60) do_write(int'($urandom_range(0, 11)), int'($urandom_range(0, 21)),
                           int'($urandom_range(0, 7)));
      do_write(10, 5, 3);
      do_write(0, 20, 6);
      do_write(15, 19, 2);
      do_swap(1, 0, 0, 0, 0);
      scan_board();
      repeat (300) probe_px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));

      // Write landing on the same edge as a swap goes to the old back bank.
      do_swap(1, 1, 7, 15, 4);
      probe_px(BX + 7 * 16 + 5, BY + 15 * 16 + 5);
      scan_board();

      // Swap blocked during a clear, granted at the next V_SWAP afterwards.
      do_clear(1);
      do_swap(1, 0, 0, 0, 0);
      scan_board();

      // Reset in the middle of a clear: front returns to bank 0.
      repeat (30) do_write(int'($urandom_range(0, 9)), int'($urandom_range(6, 19)),
                           int'($urandom_range(1, 7)));
      do_clear(2);
      scan_board();

      probe = 1'b0;
      repeat (4) @(negedge clk_25_175);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tetris_board_renderer.md
# tetris_board_renderer

Pixel source for the VGA output stage: takes the visible-area scan coordinates and returns a 12-bit colour for every pixel. It draws the 10×20 Tetris playfield from a double-buffered cell memory written by the game logic, plus a frame and background. Buffers swap only during vertical blanking, so the game never tears a frame.

## Interface
Parameters:
- BOARD_X, 240: screen x of the playfield's left cell edge. Already includes the 2-cycle pipeline compensation.
- BOARD_Y, 80: screen y of the playfield's top cell edge.
- CELL_SHIFT, 4: log2 of cell size in pixels (16 px cells, 160×320 playfield).
- FRAME_W, 4: width in px of the border drawn around the playfield.
- V_SWAP, 480: vertical line on which buffer swaps occur (first blanking line).
- BG_COLOR, 12'h222; FRAME_COLOR, 12'hAAA; EMPTY_COLOR, 12'h111: colours in {b,g,r} nibble order.

Ports:
- clk_25_175  in  1  pixel clock.
- reset  in  1  synchronous, active-low.
- hpos  in  10  current scan x from the VGA stage.
- vpos  in  10  current scan y from the VGA stage.
- pixstream  out  12  colour, [3:0]=r, [7:4]=g, [11:8]=b.
- wr_en  in  1  write one cell of the back buffer this cycle.
- wr_col  in  4  cell column, 0..9.
- wr_row  in  5  cell row, 0..19 (0 = top).
- wr_color  in  3  piece index, 0 = empty, 1..7 = I,O,T,S,Z,J,L.
- clr_req  in  1  start clearing the back buffer.
- busy  out  1  clear in progress.
- swap_req  in  1  level: request a front/back swap.
- swap_ack  out  1  1-cycle pulse when the swap takes effect.

## Operation
- Memory: two banks of 200×3 bits. Address = row*10 + col. A front bank bit selects which bank is displayed; the other bank is the back bank. Reset sets front = 0. Reset does not clear bank contents; the game issues clr_req after reset.
- Writes: wr_en writes wr_color into the back bank. The write is ignored if wr_col > 9, if wr_row > 19, or while busy = 1.
- Clear: clr_req while busy = 0 sets busy. The block then writes 0 to back-bank addresses 0..199, one per cycle, and clears busy after address 199. clr_req while busy is ignored.
- Swap:
  - Evaluated every cycle with vpos == V_SWAP and hpos == 0. If swap_req = 1 and busy = 0, the front bit toggles and swap_ack pulses.
  - Otherwise the swap waits for the next frame's V_SWAP line.
  - The game holds swap_req until it sees swap_ack.
- Pixel classification, in priority order:
  1. Inside the playfield (BOARD_X ≤ x < BOARD_X+160, BOARD_Y ≤ y < BOARD_Y+320): cell colour from the front bank.
  2. Within FRAME_W px outside the playfield rectangle: FRAME_COLOR.
  3. Anything else: BG_COLOR.
- Cell colour:
  - Index 0 → EMPTY_COLOR.
  - Indices 1..7 → 0FF0, 00FF, 0F0A, 00F0, 000F, 0F00, 008F (12'h, {b,g,r}): cyan, yellow, purple, green, red, blue, orange.
  - Outline: when the cell-local x or y offset is 0 and the index is nonzero, every nibble is shifted right by 1.
- Arithmetic: the (x − BOARD_X) and (y − BOARD_Y) subtractions are 11-bit signed so no wrap occurs. Column = dx >> CELL_SHIFT, row = dy >> CELL_SHIFT.

## Timing
- Pipeline latency is 2 cycles:
  - Edge 1: coordinates classified, RAM read issued (synchronous read), region and outline flags registered.
  - Edge 2: palette lookup, pixstream registered.
- The VGA stage adds its own fixed delay; BOARD_X absorbs the horizontal shift.
- Reset values: pixstream = 0, busy = 0, swap_ack = 0, front = 0, clear counter = 0. Reset mid-clear aborts the clear; the bank is left partly cleared.
- Same-cycle events:
  - A swap and a game write in the same cycle: the write goes to the bank that was back before the edge.
  - clr_req and wr_en in the same cycle with busy = 0: clear starts and the write is performed.
- The display read port is independent of the write/clear port, and always reads the front bank.
- A swap takes effect for pixels read from the next cycle on. Those pixels are in blanking, so the visible frame is always one bank.

## Test plan
- Reset held low 3 cycles → pixstream = 0, busy = 0, swap_ack = 0. Release, scan (0,0) → pixstream = 12'h222 two cycles later.
- clr_req, then write col 3, row 5, color 5 in the back bank, swap_req → swap_ack at vpos 480, hpos 0. Next frame:
  - Pixel (BOARD_X+56, BOARD_Y+88) → 12'h00F.
  - Pixel (BOARD_X+48, BOARD_Y+88) → 12'h007 (outline).
- Pixel (BOARD_X−2, BOARD_Y+10) → 12'hAAA. Pixel (BOARD_X+159, BOARD_Y+319) → EMPTY_COLOR after a clear.
- Writes with col = 10 or row = 20 → no RAM change; a readback of all 200 cells is unchanged.
- swap_req during a clear (busy = 1 at V_SWAP) → no swap_ack that frame. swap_ack comes at the next V_SWAP after busy falls 200 cycles later.
- Reset asserted mid-clear at count 50 → busy = 0 next cycle, front = 0, no swap_ack.
